// File: rtl/flat_stream_reader_pkg.sv
// Shared types and constants for the flattened-result stream reader.
package flat_stream_reader_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Result-memory bank select codes.
  localparam logic [2:0] CSEL_L0_K0 = 3'b001;
  localparam logic [2:0] CSEL_L0_K1 = 3'b010;
  localparam logic [2:0] CSEL_L1_K0 = 3'b011;
  localparam logic [2:0] CSEL_L1_K1 = 3'b100;
  localparam logic [2:0] CSEL_FLAT  = 3'b101;

endpackage

// File: rtl/flat_stream_reader_fifo.sv
// Two-entry FIFO carrying a data word plus a last tag. Push and pop in the
// same cycle both take effect and leave the count unchanged.
module stream_fifo2 #(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_push_last,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [1:0]        o_count,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_data [2];
  logic [1:0]        r_last;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign w_pop   = i_pop & (r_count != 2'd0);
  assign w_push  = i_push & ((r_count != 2'd2) | w_pop);
  assign o_data  = r_data[r_rd_ptr];
  assign o_last  = r_last[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);

  // Storage, pointers and occupancy; flush empties without touching payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last    <= 2'b00;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_last[r_wr_ptr] <= i_push_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/flat_stream_reader.sv
// Streams the flattened result bank out of the convolution engine's result
// memory once the engine goes idle (busy falling edge). Reads are throttled
// so the 2-entry output FIFO can never overflow; busy rising mid-run aborts.
module flat_stream_reader
  import flat_stream_reader_pkg::*;
#(
  parameter int         ADDR_W   = ADDR_W_DEF,
  parameter int         DATA_W   = DATA_W_DEF,
  parameter int         DEPTH    = 2048,
  parameter logic [2:0] BANK_SEL = CSEL_FLAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [2:0]        csel,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              done,
  output logic              active
);

  localparam logic [ADDR_W:0] LP_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_busy_d;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W-1:0] r_caddr;
  logic [2:0]        r_csel;
  logic              r_inflight;
  logic              r_inflight_last;

  logic              w_start;
  logic              w_abort;
  logic              w_pop;
  logic              w_issue;
  logic              w_issue_last;
  logic [2:0]        w_occ;
  logic [1:0]        w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_last;
  logic [DATA_W-1:0] w_fifo_data;

  assign w_start = r_busy_d & ~busy;
  assign w_abort = busy & ~r_busy_d &
                   ((r_state == ST_READ) | (r_state == ST_DRAIN));
  assign w_pop   = out_valid & out_ready;

  // Occupancy the FIFO will have once this cycle's push/pop settle. A pop in
  // the current cycle frees a slot, which is what sustains one word per cycle
  // with the two-cycle read latency.
  assign w_occ = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign w_issue      = (r_state == ST_READ) & ~w_abort & (w_occ < 3'd2);
  assign w_issue_last = w_issue & (r_issued == LP_LAST);

  assign out_valid = ~w_fifo_empty;
  assign out_data  = w_fifo_data;
  assign out_last  = w_fifo_last & ~w_fifo_empty;

  // State register and busy edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_busy_d <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_busy_d <= busy;
    end
  end

  // Next-state logic and read-port / status outputs.
  always_comb begin
    w_state_next = r_state;
    crd          = 1'b0;
    caddr_rd     = r_caddr;
    csel         = r_csel;
    done         = 1'b0;
    active       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        active = 1'b0;
        csel   = 3'b000;
        if (w_start) begin
          w_state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (w_issue) begin
          crd      = 1'b1;
          caddr_rd = r_rd_ptr;
          csel     = BANK_SEL;
        end
        if (w_abort) begin
          w_state_next = ST_IDLE;
        end else if (w_issue_last) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_abort) begin
          w_state_next = ST_IDLE;
        end else if (w_occ == 3'd0) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Read pointer, issued counter, held address/select and in-flight tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr        <= '0;
      r_issued        <= '0;
      r_caddr         <= '0;
      r_csel          <= 3'b000;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_start) begin
        r_rd_ptr <= '0;
        r_issued <= '0;
      end else if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
        r_issued <= r_issued + {{ADDR_W{1'b0}}, 1'b1};
        r_caddr  <= r_rd_ptr;
        r_csel   <= BANK_SEL;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
    end
  end

  stream_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (w_abort),
    .i_push     (r_inflight),
    .i_push_data(cdata_rd),
    .i_push_last(r_inflight_last),
    .i_pop      (w_pop),
    .o_data     (w_fifo_data),
    .o_last     (w_fifo_last),
    .o_count    (w_fifo_count),
    .o_empty    (w_fifo_empty)
  );

endmodule

// File: tb/tb_flat_stream_reader.sv
// Scoreboard bench for flat_stream_reader: expected words are queued when a
// run is launched; monitors compare on every accepted handshake.
module tb_flat_stream_reader;

  localparam int AW  = 12;
  localparam int DW  = 20;
  localparam int DEP = 2048;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          busy;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [2:0]    csel;
  logic [DW-1:0] cdata_rd;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          done;
  logic          active;

  logic          b_busy;
  logic          b_crd;
  logic [AW-1:0] b_caddr_rd;
  logic [2:0]    b_csel;
  logic [DW-1:0] b_cdata_rd;
  logic          b_out_valid;
  logic [DW-1:0] b_out_data;
  logic          b_out_last;
  logic          b_out_ready;
  logic          b_done;
  logic          b_active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;

  exp_t          q[$];
  exp_t          bq[$];
  logic [AW-1:0] addrs[$];

  int n_rd_run = 0, n_acc_run = 0, n_done = 0, last_hs_cyc = -10;
  int first_crd_cyc = -1, first_val_cyc = -1, start_cyc = 0;
  bit seen_valid = 0, gap_chk = 0, prev_stall = 0;
  logic [DW-1:0] prev_data;
  int b_reads = 0, b_done_n = 0;

  always #5 clk = ~clk;

  flat_stream_reader dut (
    .clk(clk), .reset(reset), .busy(busy), .crd(crd), .caddr_rd(caddr_rd),
    .csel(csel), .cdata_rd(cdata_rd), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .done(done), .active(active)
  );

  flat_stream_reader #(.DEPTH(4), .BANK_SEL(3'b011)) dut_b (
    .clk(clk), .reset(reset), .busy(b_busy), .crd(b_crd),
    .caddr_rd(b_caddr_rd), .csel(b_csel), .cdata_rd(b_cdata_rd),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
    .out_ready(b_out_ready), .done(b_done), .active(b_active)
  );

  // Result memory models: registered read, one bank meaningful per instance.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (crd) cdata_rd <= (csel == 3'b101) ? DW'(caddr_rd * 3) : 20'hDEAD0;
    if (b_crd) b_cdata_rd <= (b_csel == 3'b011) ? DW'(b_caddr_rd * 7 + 1) : 20'hDEAD1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the default instance.
  always @(negedge clk) begin
    bit   hs;
    exp_t e;
    hs = out_valid && out_ready;
    if (gap_chk && active && n_acc_run > 0 && n_acc_run < DEP)
      chk("no_gap", out_valid, 1);
    if (prev_stall && out_valid)
      chk("stall_stable", out_data, prev_data);
    if (crd) begin
      chk("credit", ((n_rd_run - n_acc_run - int'(hs)) < 2), 1);
      chk("csel_read", csel, 3'b101);
      if (n_rd_run == 0) first_crd_cyc = cyc;
      addrs.push_back(caddr_rd);
      n_rd_run++;
    end
    if (out_valid && !seen_valid) begin
      first_val_cyc = cyc;
      seen_valid = 1;
    end
    if (hs) begin
      if (q.size() == 0) chk("unexpected_word", 1, 0);
      else begin
        e = q.pop_front();
        chk("word_data", out_data, e.d);
        chk("word_last", out_last, e.l);
      end
      n_acc_run++;
      last_hs_cyc = cyc;
    end
    if (done) begin
      chk("done_timing", cyc, last_hs_cyc + 1);
      chk("done_count", n_acc_run, DEP);
      n_done++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (!active) begin
      n_rd_run = 0;
      n_acc_run = 0;
      seen_valid = 0;
    end
  end

  // Monitor for the DEPTH=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (b_crd) begin
      chk("b_csel", b_csel, 3'b011);
      b_reads++;
    end
    if (b_out_valid && b_out_ready) begin
      if (bq.size() == 0) chk("b_unexpected_word", 1, 0);
      else begin
        e = bq.pop_front();
        $display("b word: data=%0d last=%0d", b_out_data, b_out_last);
        chk("b_word_data", b_out_data, e.d);
        chk("b_word_last", b_out_last, e.l);
      end
    end
    if (b_done) b_done_n++;
  end

  // out_ready driver: 0 = held low, 1 = held high, 2 = random ~30% low.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 9) >= 3);
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp();
    for (int i = 0; i < DEP; i++) q.push_back('{DW'(i * 3), (i == DEP - 1)});
  endtask

  task automatic start_run();
    busy = 1'b1;
    step(3);
    busy = 1'b0;
    start_cyc = cyc;
    step(1);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = n_done;
    k = 0;
    while (n_done == d0 && k < budget) begin
      step(1);
      k++;
    end
    chk("done_timeout", (n_done != d0), 1);
    step(2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_crd"}, crd, 0);
    chk({tag, "_caddr"}, caddr_rd, 0);
    chk({tag, "_csel"}, csel, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_active"}, active, 0);
  endtask

  initial begin
    int k;
    int d0;
    reset = 1'b1;
    busy = 1'b0;
    b_busy = 1'b0;
    b_out_ready = 1'b1;
    #1;
    chk_reset_outputs("reset");
    step(3);
    reset = 1'b0;
    step(2);

    // Full run, ready held high: latency, ordering, no gaps, done timing.
    $display("run 1: ready high");
    rdy_mode = 1;
    step(2);
    gap_chk = 1;
    addrs.delete();
    push_exp();
    start_run();
    wait_done(3000);
    gap_chk = 0;
    chk("q_empty_1", q.size(), 0);
    chk("first_crd_lat", first_crd_cyc, start_cyc + 1);
    chk("first_valid_lat", first_val_cyc, start_cyc + 3);
    chk("active_after_done", active, 0);

    // Full run with random back-pressure.
    $display("run 2: random ready");
    rdy_mode = 2;
    push_exp();
    start_run();
    wait_done(9000);
    chk("q_empty_2", q.size(), 0);

    // Ready low from start: exactly two reads, then resume at address 2.
    $display("run 3: ready held low");
    rdy_mode = 0;
    step(2);
    addrs.delete();
    push_exp();
    start_run();
    step(20);
    chk("stall_reads", addrs.size(), 2);
    if (addrs.size() >= 2) begin
      chk("stall_addr0", addrs[0], 0);
      chk("stall_addr1", addrs[1], 1);
    end
    chk("stall_valid", out_valid, 1);
    addrs.delete();
    rdy_mode = 1;
    wait_done(3000);
    chk("resume_nonempty", (addrs.size() > 0), 1);
    if (addrs.size() > 0) chk("resume_addr", addrs[0], 2);
    chk("q_empty_3", q.size(), 0);

    // Abort after 100 accepted words, then a clean restart from address 0.
    $display("run 4: abort");
    push_exp();
    start_run();
    k = 0;
    while (n_acc_run < 100 && k < 500) begin
      step(1);
      k++;
    end
    chk("abort_reach_100", (n_acc_run >= 100), 1);
    d0 = n_done;
    busy = 1'b1;
    step(1);
    chk("abort_crd", crd, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_active", active, 0);
    q.delete();
    step(10);
    chk("abort_no_done", n_done, d0);
    addrs.delete();
    push_exp();
    start_run();
    wait_done(3000);
    chk("restart_addr0", (addrs.size() > 0) ? addrs[0] : 12'hFFF, 0);
    chk("q_empty_4", q.size(), 0);

    // Asynchronous reset mid-READ, then a full run.
    $display("run 5: reset mid-run");
    push_exp();
    start_run();
    step(50);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(2);
    push_exp();
    start_run();
    wait_done(3000);
    chk("q_empty_5", q.size(), 0);

    // DEPTH=4 / BANK_SEL=3 instance.
    $display("run 6: DEPTH=4 instance");
    for (int i = 0; i < 4; i++) bq.push_back('{DW'(i * 7 + 1), (i == 3)});
    b_busy = 1'b1;
    step(3);
    b_busy = 1'b0;
    k = 0;
    while (b_done_n == 0 && k < 50) begin
      step(1);
      k++;
    end
    chk("b_done", b_done_n, 1);
    chk("b_reads", b_reads, 4);
    chk("b_q_empty", bq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
